clk_en_gen: RTL and testbench

CLK_EN_GEN -- requirements
Module: clk_en_gen

---
 rtl/clk_en_pkg.sv | 18 +
 rtl/clk_en_gen_cnt.sv | 40 ++++
 rtl/clk_en_gen.sv | 161 ++++++++++++++++
 tb/tb_clk_en_gen.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_en_pkg.sv
// Shared definitions for the clock-enable generator: FSM state encoding,
// mode constants and default parameter values.
package clk_en_pkg;

    localparam int DEF_WIDTH = 25;
    localparam int DEF_DIV   = 32;
    localparam int DEF_CNT_W = 16;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    localparam logic MODE_PERIODIC = 1'b0;
    localparam logic MODE_ONESHOT  = 1'b1;

endpackage

// File: rtl/clk_en_gen_cnt.sv
// Period counter for clk_en_gen: counts 0..limit and flags the wrap edge.
// limit is the terminal count (period minus one).
module clk_en_cnt
    import clk_en_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic [WIDTH-1:0] limit,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    assign wrap = enable && (cnt_q == limit);

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = wrap ? '0 : cnt_q + ONE;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/clk_en_gen.sv
// Programmable clock-enable generator (periodic / one-shot) with shadowed divisor.
// Optional square-wave output sq_out when CLK_EN_GEN_SQUARE_EN is defined.
module clk_en_gen
    import clk_en_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int DEFAULT_DIV = DEF_DIV,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             run,
    input  logic             mode,
    input  logic             div_load,
    input  logic [WIDTH-1:0] div_value,
    output logic             clock_en,
    output logic             busy,
    output logic             done,
    output logic             div_pending,
    output logic [CNT_W-1:0] tick_count
`ifdef CLK_EN_GEN_SQUARE_EN
    ,
    output logic             sq_out
`endif
);

    localparam logic [WIDTH-1:0] DIV_RST  = DEFAULT_DIV[WIDTH-1:0];
    localparam logic [WIDTH-1:0] DIV_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] TICK_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic             mode_q, mode_d;
    logic [WIDTH-1:0] div_active_q, div_active_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic             pending_q, pending_d;
    logic             clk_en_q, clk_en_d;
    logic [CNT_W-1:0] tick_q, tick_d;

    logic             run_cnt;
    logic             wrap;
    logic [WIDTH-1:0] limit;

    // A divisor of 0 behaves as 1, so both map to terminal count 0.
    assign limit   = (div_active_q == '0) ? '0 : div_active_q - DIV_ONE;
    assign run_cnt = (state_q == ST_RUN) && run;

    clk_en_cnt #(
        .WIDTH (WIDTH)
    ) u_cnt (
        .clock  (clock),
        .reset  (reset),
        .clear  (!run_cnt),
        .enable (run_cnt),
        .limit  (limit),
        .wrap   (wrap)
    );

    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        div_active_d = div_active_q;
        shadow_d     = shadow_q;
        pending_d    = pending_q;
        clk_en_d     = wrap;
        tick_d       = wrap ? tick_q + TICK_ONE : tick_q;

        case (state_q)
            ST_IDLE: begin
                if (div_load) begin
                    div_active_d = div_value;
                    pending_d    = 1'b0;
                end
                if (run) begin
                    state_d = ST_RUN;
                    mode_d  = mode;
                end
            end
            ST_RUN: begin
                if (div_load) begin
                    shadow_d  = div_value;
                    pending_d = 1'b1;
                end
                // Leaving RUN commits any outstanding divisor so it is not lost.
                if (!run || wrap) begin
                    if (div_load) begin
                        div_active_d = div_value;
                    end else if (pending_q) begin
                        div_active_d = shadow_q;
                    end
                    pending_d = 1'b0;
                end
                if (!run) begin
                    state_d = ST_IDLE;
                end else if (wrap && (mode_q == MODE_ONESHOT)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (div_load) begin
                    div_active_d = div_value;
                    pending_d    = 1'b0;
                end
                if (!run) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            mode_q       <= MODE_PERIODIC;
            div_active_q <= DIV_RST;
            shadow_q     <= '0;
            pending_q    <= 1'b0;
            clk_en_q     <= 1'b0;
            tick_q       <= '0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            div_active_q <= div_active_d;
            shadow_q     <= shadow_d;
            pending_q    <= pending_d;
            clk_en_q     <= clk_en_d;
            tick_q       <= tick_d;
        end
    end

`ifdef CLK_EN_GEN_SQUARE_EN
    logic sq_q, sq_d;

    always_comb begin
        sq_d = sq_q;
        if (wrap) begin
            sq_d = ~sq_q;
        end
        if (state_d == ST_IDLE) begin
            sq_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            sq_q <= 1'b0;
        end else begin
            sq_q <= sq_d;
        end
    end

    assign sq_out = sq_q;
`endif

    assign clock_en    = clk_en_q;
    assign busy        = (state_q == ST_RUN);
    assign done        = (state_q == ST_DONE);
    assign div_pending = pending_q;
    assign tick_count  = tick_q;

endmodule

// File: tb/tb_clk_en_gen.sv
// Directed self-checking bench for clk_en_gen; a second instance with CNT_W=4
// exercises tick_count wrap. sq_out checks compile in with CLK_EN_GEN_SQUARE_EN.
module tb_clk_en_gen;

    logic        clock;
    logic        reset;
    logic        run;
    logic        mode;
    logic        div_load;
    logic [24:0] div_value;

    logic        clock_en, busy, done, div_pending;
    logic [15:0] tick_count;
    logic        clock_en_n, busy_n, done_n, div_pending_n;
    logic [3:0]  tick_count_n;
`ifdef CLK_EN_GEN_SQUARE_EN
    logic        sq_out, sq_out_n;
`endif

    int checks;
    int failures;

    clk_en_gen dut (
        .clock       (clock),
        .reset       (reset),
        .run         (run),
        .mode        (mode),
        .div_load    (div_load),
        .div_value   (div_value),
        .clock_en    (clock_en),
        .busy        (busy),
        .done        (done),
        .div_pending (div_pending),
        .tick_count  (tick_count)
`ifdef CLK_EN_GEN_SQUARE_EN
        ,
        .sq_out      (sq_out)
`endif
    );

    clk_en_gen #(.CNT_W(4)) dut_n (
        .clock       (clock),
        .reset       (reset),
        .run         (run),
        .mode        (mode),
        .div_load    (div_load),
        .div_value   (div_value),
        .clock_en    (clock_en_n),
        .busy        (busy_n),
        .done        (done_n),
        .div_pending (div_pending_n),
        .tick_count  (tick_count_n)
`ifdef CLK_EN_GEN_SQUARE_EN
        ,
        .sq_out      (sq_out_n)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset = 1'b0; run = 1'b0; mode = 1'b0; div_load = 1'b0; div_value = '0;
        step();
        step();
        reset = 1'b1;
        step();
    endtask

    task automatic load_idle(input logic [24:0] v);
        div_load = 1'b1;
        div_value = v;
        step();
        div_load = 1'b0;
    endtask

    task automatic wait_pulse(input int max_cyc, output int cyc);
        cyc = -1;
        for (int i = 1; i <= max_cyc; i++) begin
            step();
            if (clock_en === 1'b1) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; run = 1'b1; mode = 1'b0; div_load = 1'b1; div_value = 25'd7;
        step();
        step();
        checks++; if (clock_en !== 1'b0) begin failures++; $display("FAIL rst_clock_en got=%0b exp=0", clock_en); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%0b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL rst_done got=%0b exp=0", done); end
        checks++; if (div_pending !== 1'b0) begin failures++; $display("FAIL rst_pending got=%0b exp=0", div_pending); end
        checks++; if (tick_count !== 16'd0) begin failures++; $display("FAIL rst_tick got=%0d exp=0", tick_count); end
        run = 1'b0; div_load = 1'b0; reset = 1'b1;
        step();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_idle_busy got=%0b exp=0", busy); end
    endtask

    task automatic test_periodic();
        int c;
        do_reset();
        run = 1'b1; mode = 1'b0;
        step();
        for (int p = 0; p < 3; p++) begin
            wait_pulse(40, c);
            checks++; if (c !== 32) begin failures++; $display("FAIL periodic_gap%0d got=%0d exp=32", p, c); end
        end
        checks++; if (tick_count !== 16'd3) begin failures++; $display("FAIL periodic_tick got=%0d exp=3", tick_count); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL periodic_busy got=%0b exp=1", busy); end
        run = 1'b0;
        step();
        checks++; if (clock_en !== 1'b0) begin failures++; $display("FAIL periodic_stop_en got=%0b exp=0", clock_en); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL periodic_stop_busy got=%0b exp=0", busy); end
    endtask

    task automatic test_oneshot();
        int c;
        int extra;
        do_reset();
        load_idle(25'd5);
        mode = 1'b1; run = 1'b1;
        step();
        wait_pulse(20, c);
        checks++; if (c !== 5) begin failures++; $display("FAIL oneshot_latency got=%0d exp=5", c); end
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL oneshot_done got=%0b exp=1", done); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL oneshot_busy got=%0b exp=0", busy); end
        extra = 0;
        repeat (50) begin
            step();
            if (clock_en === 1'b1) extra++;
        end
        checks++; if (extra !== 0) begin failures++; $display("FAIL oneshot_extra got=%0d exp=0", extra); end
        checks++; if (tick_count !== 16'd1) begin failures++; $display("FAIL oneshot_tick got=%0d exp=1", tick_count); end
        run = 1'b0;
        step();
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL oneshot_idle_done got=%0b exp=0", done); end
        mode = 1'b0;
    endtask

    task automatic test_div_change();
        int c;
        do_reset();
        load_idle(25'd10);
        run = 1'b1; mode = 1'b0;
        step();
        repeat (3) step();
        div_load = 1'b1; div_value = 25'd7;
        step();
        div_load = 1'b0;
        checks++; if (div_pending !== 1'b1) begin failures++; $display("FAIL chg_pending_set got=%0b exp=1", div_pending); end
        repeat (5) step();
        checks++; if (div_pending !== 1'b1) begin failures++; $display("FAIL chg_pending_hold got=%0b exp=1", div_pending); end
        checks++; if (clock_en !== 1'b0) begin failures++; $display("FAIL chg_early_pulse got=%0b exp=0", clock_en); end
        step();
        checks++; if (clock_en !== 1'b1) begin failures++; $display("FAIL chg_wrap_pulse got=%0b exp=1", clock_en); end
        checks++; if (div_pending !== 1'b0) begin failures++; $display("FAIL chg_pending_clr got=%0b exp=0", div_pending); end
        for (int p = 0; p < 2; p++) begin
            wait_pulse(20, c);
            checks++; if (c !== 7) begin failures++; $display("FAIL chg_gap%0d got=%0d exp=7", p, c); end
        end
        run = 1'b0;
        step();
    endtask

    task automatic test_div_zero_one();
        int cnt;
        for (int j = 0; j < 2; j++) begin
            do_reset();
            load_idle(25'(j));
            run = 1'b1; mode = 1'b0;
            step();
            cnt = 0;
            repeat (6) begin
                step();
                if (clock_en === 1'b1) cnt++;
            end
            checks++; if (cnt !== 6) begin failures++; $display("FAIL div%0d_pulses got=%0d exp=6", j, cnt); end
            run = 1'b0;
            step();
            checks++; if (clock_en !== 1'b0) begin failures++; $display("FAIL div%0d_stop got=%0b exp=0", j, clock_en); end
            checks++; if (tick_count !== 16'd6) begin failures++; $display("FAIL div%0d_tick got=%0d exp=6", j, tick_count); end
        end
    endtask

    task automatic test_reset_mid();
        int c;
        do_reset();
        load_idle(25'd6);
        run = 1'b1; mode = 1'b0;
        step();
        step();
        div_load = 1'b1; div_value = 25'd9;
        step();
        div_load = 1'b0;
        checks++; if (div_pending !== 1'b1) begin failures++; $display("FAIL mid_pending got=%0b exp=1", div_pending); end
        repeat (3) step();
        reset = 1'b0;
        step();
        checks++; if (clock_en !== 1'b0) begin failures++; $display("FAIL mid_clock_en got=%0b exp=0", clock_en); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_busy got=%0b exp=0", busy); end
        checks++; if (div_pending !== 1'b0) begin failures++; $display("FAIL mid_pending_clr got=%0b exp=0", div_pending); end
        checks++; if (tick_count !== 16'd0) begin failures++; $display("FAIL mid_tick got=%0d exp=0", tick_count); end
        reset = 1'b1;
        step();
        wait_pulse(40, c);
        checks++; if (c !== 32) begin failures++; $display("FAIL mid_div_default got=%0d exp=32", c); end
        run = 1'b0;
        step();
    endtask

    task automatic test_tick_wrap();
        do_reset();
        load_idle(25'd1);
        run = 1'b1; mode = 1'b0;
        step();
        repeat (15) step();
        checks++; if (tick_count_n !== 4'd15) begin failures++; $display("FAIL wrap_tick15 got=%0d exp=15", tick_count_n); end
        step();
        checks++; if (tick_count_n !== 4'd0) begin failures++; $display("FAIL wrap_tick0 got=%0d exp=0", tick_count_n); end
        step();
        checks++; if (tick_count_n !== 4'd1) begin failures++; $display("FAIL wrap_tick1 got=%0d exp=1", tick_count_n); end
        checks++; if (tick_count !== 16'd17) begin failures++; $display("FAIL wrap_tick_wide got=%0d exp=17", tick_count); end
        run = 1'b0;
        step();
    endtask

`ifdef CLK_EN_GEN_SQUARE_EN
    task automatic test_square();
        do_reset();
        load_idle(25'd4);
        run = 1'b1; mode = 1'b0;
        step();
        repeat (3) step();
        checks++; if (sq_out !== 1'b0) begin failures++; $display("FAIL sq_k3 got=%0b exp=0", sq_out); end
        step();
        checks++; if (sq_out !== 1'b1) begin failures++; $display("FAIL sq_k4 got=%0b exp=1", sq_out); end
        repeat (3) step();
        checks++; if (sq_out !== 1'b1) begin failures++; $display("FAIL sq_k7 got=%0b exp=1", sq_out); end
        step();
        checks++; if (sq_out !== 1'b0) begin failures++; $display("FAIL sq_k8 got=%0b exp=0", sq_out); end
        repeat (4) step();
        checks++; if (sq_out !== 1'b1) begin failures++; $display("FAIL sq_k12 got=%0b exp=1", sq_out); end
        run = 1'b0;
        step();
        checks++; if (sq_out !== 1'b0) begin failures++; $display("FAIL sq_idle got=%0b exp=0", sq_out); end
    endtask
`endif

    initial begin
        checks = 0;
        failures = 0;
        reset = 1'b0; run = 1'b0; mode = 1'b0; div_load = 1'b0; div_value = '0;
        test_reset();
        test_periodic();
        test_oneshot();
        test_div_change();
        test_div_zero_one();
        test_reset_mid();
        test_tick_wrap();
`ifdef CLK_EN_GEN_SQUARE_EN
        test_square();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
